// File: rtl/scratchpad_drain_if.sv
// Scratchpad read port plus downstream valid/ready stream, as seen by the drain sequencer.
interface scratchpad_drain_if #(
  parameter int unsigned W     = 100,
  parameter int unsigned ADDRW = 5
);
  logic             sp_on;
  logic             sp_write_enable;
  logic [ADDRW-1:0] sp_address;
  logic [W-1:0]     sp_data_out;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             out_last;

  // Sequencer side: drives reads and the stream.
  modport master (
    output sp_on, sp_write_enable, sp_address,
    input  sp_data_out,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  // Scratchpad/consumer side.
  modport slave (
    input  sp_on, sp_write_enable, sp_address,
    output sp_data_out,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/scratchpad_drain.sv
// Read-side sequencer: walks [base_addr, base_addr+length) modulo SIZE, absorbs the
// scratchpad's 1-cycle read latency in a 2-entry FIFO and streams words out valid/ready.
module scratchpad_drain #(
  parameter int unsigned NUMHELPER = 4,
  parameter int unsigned BITWIDTH  = 25,
  parameter int unsigned SIZE      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(SIZE)-1:0]   base_addr,
  input  logic [$clog2(SIZE):0]     length,
  output logic                      busy,
  output logic                      done,
  scratchpad_drain_if.master        bus
);
  localparam int unsigned W     = NUMHELPER * BITWIDTH;
  localparam int unsigned ADDRW = $clog2(SIZE);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;         // next address to read
  logic [ADDRW-1:0] sp_addr_q, sp_addr_d;   // last issued address, held while idle
  logic [ADDRW:0]   reads_left_q, reads_left_d;
  logic [ADDRW:0]   beats_left_q, beats_left_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [W-1:0]     buf_q [2];
  logic [W-1:0]     buf_d [2];

  logic       issue, push, pop;
  logic [2:0] occupancy;

  // Issue/push/pop decisions and all next-state values.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sp_addr_d    = sp_addr_q;
    reads_left_d = reads_left_q;
    beats_left_d = beats_left_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    buf_d        = buf_q;

    pop       = (count_q != 2'd0) && bus.out_ready;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    // A read is only issued when its data is guaranteed a free slot next cycle.
    issue     = (state_q == StRun) && (reads_left_q != '0) && ((occupancy < 3'd2) || pop);
    inflight_d = issue;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d       = base_addr;
          reads_left_d = length;
          beats_left_d = length;
          state_d      = (length == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (pop && (beats_left_q == (ADDRW+1)'(1))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (issue) begin
      sp_addr_d    = addr_q;
      addr_d       = (addr_q == ADDRW'(SIZE - 1)) ? '0 : addr_q + ADDRW'(1);
      reads_left_d = reads_left_q - (ADDRW+1)'(1);
    end

    if (push) begin
      buf_d[wr_ptr_q] = bus.sp_data_out;
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d     = ~rd_ptr_q;
      beats_left_d = beats_left_q - (ADDRW+1)'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset aborts any command and drops buffered words.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      sp_addr_q    <= '0;
      reads_left_q <= '0;
      beats_left_q <= '0;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      buf_q[0]     <= '0;
      buf_q[1]     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sp_addr_q    <= sp_addr_d;
      reads_left_q <= reads_left_d;
      beats_left_q <= beats_left_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      buf_q[0]     <= buf_d[0];
      buf_q[1]     <= buf_d[1];
    end
  end

  assign busy                = (state_q == StRun);
  assign done                = (state_q == StDone);
  assign bus.sp_on           = issue;
  assign bus.sp_write_enable = 1'b0;
  assign bus.sp_address      = issue ? addr_q : sp_addr_q;
  assign bus.out_valid       = (count_q != 2'd0);
  assign bus.out_data        = buf_q[rd_ptr_q];
  assign bus.out_last        = (count_q != 2'd0) && (beats_left_q == (ADDRW+1)'(1));
endmodule

// File: tb/tb_scratchpad_drain.sv
// Self-checking bench for scratchpad_drain: scratchpad memory model plus stream observer.
module tb_scratchpad_drain;
  localparam int unsigned SIZE  = 32;
  localparam int unsigned W     = 100;
  localparam int unsigned ADDRW = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [ADDRW-1:0] base_addr;
  logic [ADDRW:0]   length;
  logic             busy, done;

  scratchpad_drain_if #(.W(W), .ADDRW(ADDRW)) bus ();

  scratchpad_drain #(.NUMHELPER(4), .BITWIDTH(25), .SIZE(SIZE)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  // Scratchpad model: data appears the cycle after a read.
  logic [W-1:0] mem [SIZE];
  always @(posedge clock) if (bus.sp_on === 1'b1) bus.sp_data_out <= mem[bus.sp_address];

  int errors = 0;
  int checks = 0;

  // Observations of one command.
  logic [W-1:0] obs_data [$];
  bit           obs_last [$];
  int           obs_cyc  [$];
  int           obs_addr [$];
  int done_cyc, done_cnt, max_outst, stall_viol, we_viol;
  logic busy_at1;

  function automatic logic [W-1:0] rand_word();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic bit ready_for(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fill_random();
    for (int k = 0; k < SIZE; k++) mem[k] = rand_word();
  endtask

  // Issues one command and records what the DUT does; cycle 0 is the cycle start is presented.
  task automatic run_stream(input int base, input int len, input int mode,
                            input int abort_after, input int inj_cycle);
    int issued, popped;
    bit prev_stall;
    logic [W-1:0] prev_data;
    obs_data.delete(); obs_last.delete(); obs_cyc.delete(); obs_addr.delete();
    done_cyc = -1; done_cnt = 0; max_outst = 0; stall_viol = 0; we_viol = 0;
    issued = 0; popped = 0; prev_stall = 0; prev_data = '0; busy_at1 = 1'b0;
    @(negedge clock);
    start = 1'b1; base_addr = base[ADDRW-1:0]; length = len[ADDRW:0];
    for (int c = 0; c < 400; c++) begin
      if (c > 0) begin
        @(negedge clock);
        start = (c == inj_cycle);
        if (c == inj_cycle) begin
          base_addr = 5'(base + 11);
          length    = 6'd3;
        end
      end
      bus.out_ready = ready_for(mode, c);
      #1;
      if (issued - popped > max_outst) max_outst = issued - popped;
      if (bus.sp_write_enable !== 1'b0) we_viol++;
      if (bus.sp_on === 1'b1) begin
        obs_addr.push_back(int'(bus.sp_address));
        issued++;
      end
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) stall_viol++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        obs_data.push_back(bus.out_data);
        obs_last.push_back(bus.out_last);
        obs_cyc.push_back(c);
        popped++;
      end
      prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
      prev_data  = bus.out_data;
      if (c == 1) busy_at1 = busy;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (abort_after > 0 && popped == abort_after) begin
        start = 1'b0;
        return;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (bus.sp_on !== 1'b0) begin errors++; $display("FAIL reset_sp_on got=%b want=0", bus.sp_on); end
    checks++; if (bus.sp_address !== 5'd0) begin errors++; $display("FAIL reset_sp_address got=%0d want=0", bus.sp_address); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%0h want=0", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", bus.out_last); end
    checks++; if (bus.sp_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", bus.sp_write_enable); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < SIZE; k++) mem[k] = W'(k);
    run_stream(0, 7, 0, 0, -1);
    checks++; if (obs_data.size() != 7) begin errors++; $display("FAIL basic_count got=%0d want=7", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 7; i++) begin
      checks++; if (obs_data[i] !== W'(i)) begin errors++; $display("FAIL basic_data[%0d] got=%0h want=%0h", i, obs_data[i], i); end
      checks++; if (obs_cyc[i] != 3 + i) begin errors++; $display("FAIL basic_cycle[%0d] got=%0d want=%0d", i, obs_cyc[i], 3 + i); end
      checks++; if (obs_last[i] != (i == 6)) begin errors++; $display("FAIL basic_last[%0d] got=%0d want=%0d", i, obs_last[i], i == 6); end
    end
    checks++; if (done_cyc != 10) begin errors++; $display("FAIL basic_done_cycle got=%0d want=10", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_width got=%0d want=1", done_cnt); end
    checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", busy_at1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    checks++; if (we_viol != 0) begin errors++; $display("FAIL basic_we got=%0d want=0", we_viol); end
  endtask

  // Back-pressure: alternating ready, then fully random ready/base/length.
  task automatic test_backpressure();
    for (int r = 0; r < 5; r++) begin
      int base, len, mode;
      fill_random();
      base = (r == 0) ? 0 : int'($urandom_range(0, SIZE - 1));
      len  = (r == 0) ? 7 : int'($urandom_range(1, SIZE));
      mode = (r == 0) ? 1 : 2;
      run_stream(base, len, mode, 0, -1);
      checks++; if (obs_data.size() != len) begin errors++; $display("FAIL bp%0d_count got=%0d want=%0d", r, obs_data.size(), len); end
      for (int i = 0; i < obs_data.size() && i < len; i++) begin
        checks++; if (obs_data[i] !== mem[(base + i) % SIZE]) begin errors++; $display("FAIL bp%0d_data[%0d] got=%0h want=%0h", r, i, obs_data[i], mem[(base + i) % SIZE]); end
        checks++; if (obs_last[i] != (i == len - 1)) begin errors++; $display("FAIL bp%0d_last[%0d] got=%0d want=%0d", r, i, obs_last[i], i == len - 1); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp%0d_stable got=%0d want=0", r, stall_viol); end
      checks++; if (max_outst > 2) begin errors++; $display("FAIL bp%0d_outstanding got=%0d want<=2", r, max_outst); end
      if (obs_cyc.size() > 0) begin
        checks++; if (done_cyc != obs_cyc[obs_cyc.size() - 1] + 1) begin errors++; $display("FAIL bp%0d_done_cycle got=%0d want=%0d", r, done_cyc, obs_cyc[obs_cyc.size() - 1] + 1); end
      end
    end
  endtask

  task automatic test_wrap();
    fill_random();
    run_stream(30, 4, 0, 0, -1);
    checks++; if (obs_addr.size() != 4) begin errors++; $display("FAIL wrap_reads got=%0d want=4", obs_addr.size()); end
    for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
      checks++; if (obs_addr[i] != (30 + i) % SIZE) begin errors++; $display("FAIL wrap_addr[%0d] got=%0d want=%0d", i, obs_addr[i], (30 + i) % SIZE); end
    end
    for (int i = 0; i < obs_data.size() && i < 4; i++) begin
      checks++; if (obs_data[i] !== mem[(30 + i) % SIZE]) begin errors++; $display("FAIL wrap_data[%0d] got=%0h want=%0h", i, obs_data[i], mem[(30 + i) % SIZE]); end
    end
  endtask

  task automatic test_lengths();
    run_stream(9, 0, 0, 0, -1);
    checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL len0_reads got=%0d want=0", obs_addr.size()); end
    checks++; if (obs_data.size() != 0) begin errors++; $display("FAIL len0_beats got=%0d want=0", obs_data.size()); end
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL len0_done_cycle got=%0d want=1", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL len0_done_width got=%0d want=1", done_cnt); end
    fill_random();
    run_stream(5, 32, 0, 0, -1);
    checks++; if (obs_data.size() != 32) begin errors++; $display("FAIL full_count got=%0d want=32", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 32; i++) begin
      checks++; if (obs_data[i] !== mem[(5 + i) % SIZE]) begin errors++; $display("FAIL full_data[%0d] got=%0h want=%0h", i, obs_data[i], mem[(5 + i) % SIZE]); end
    end
    for (int i = 0; i < obs_addr.size() && i < 32; i++) begin
      checks++; if (obs_addr[i] != (5 + i) % SIZE) begin errors++; $display("FAIL full_addr[%0d] got=%0d want=%0d", i, obs_addr[i], (5 + i) % SIZE); end
    end
    checks++; if (done_cyc != 35) begin errors++; $display("FAIL full_done_cycle got=%0d want=35", done_cyc); end
  endtask

  task automatic test_start_ignored();
    fill_random();
    run_stream(8, 6, 0, 0, 2);
    checks++; if (obs_data.size() != 6) begin errors++; $display("FAIL ign_count got=%0d want=6", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 6; i++) begin
      checks++; if (obs_data[i] !== mem[8 + i]) begin errors++; $display("FAIL ign_data[%0d] got=%0h want=%0h", i, obs_data[i], mem[8 + i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_width got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_stream(4, 10, 0, 3, -1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_busy_done got=%b%b want=00", busy, done); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL abort_valid_last got=%b%b want=00", bus.out_valid, bus.out_last); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL abort_data got=%0h want=0", bus.out_data); end
    checks++; if (bus.sp_on !== 1'b0 || bus.sp_address !== 5'd0) begin errors++; $display("FAIL abort_sp got=%b/%0d want=0/0", bus.sp_on, bus.sp_address); end
    run_stream(20, 5, 2, 0, -1);
    checks++; if (obs_data.size() != 5) begin errors++; $display("FAIL restart_count got=%0d want=5", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 5; i++) begin
      checks++; if (obs_data[i] !== mem[20 + i]) begin errors++; $display("FAIL restart_data[%0d] got=%0h want=%0h", i, obs_data[i], mem[20 + i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_lengths();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
